// File: rtl/apb_gpio_pkg.sv
// Shared constants, register map and FSM encoding for the APB GPIO controller.
package apb_gpio_pkg;

   localparam int unsigned DATA_W          = 32;
   localparam int unsigned STRB_W          = DATA_W / 8;
   localparam int unsigned MAX_GPIO_W      = 32;
   localparam int unsigned MAX_WAIT_STATES = 15;
   localparam int unsigned MIN_SYNC_STAGES = 2;
   localparam int unsigned MAX_SYNC_STAGES = 4;
   localparam int unsigned MIN_ADDR_W      = 6;
   localparam int unsigned CNT_W           = 4;
   localparam int unsigned OFF_W           = 4;

   // Register word indices (byte offset = index * 4)
   localparam logic [OFF_W-1:0] REG_IN    = 4'h0;
   localparam logic [OFF_W-1:0] REG_OUT   = 4'h1;
   localparam logic [OFF_W-1:0] REG_OE    = 4'h2;
   localparam logic [OFF_W-1:0] REG_AUX   = 4'h3;
   localparam logic [OFF_W-1:0] REG_INTE  = 4'h4;
   localparam logic [OFF_W-1:0] REG_PTRIG = 4'h5;
   localparam logic [OFF_W-1:0] REG_BOTH  = 4'h6;
   localparam logic [OFF_W-1:0] REG_INTS  = 4'h7;
   localparam logic [OFF_W-1:0] REG_CTRL  = 4'h8;

   localparam int unsigned CTRL_IE = 0;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } apb_state_e;

   // Expand byte strobes into a per-bit write mask
   function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int unsigned b = 0; b < STRB_W; b++) begin
         m[b*8 +: 8] = {8{strb[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-flop input synchroniser plus one history flop for edge detection.
module gpio_sync_edge #(
   parameter int unsigned W      = 32,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] sync_o,
   output logic [W-1:0] rise_c_o,
   output logic [W-1:0] fall_c_o
);

   logic [W-1:0] sync_q [STAGES];
   logic [W-1:0] prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            sync_q[s] <= '0;
         end
         prev_q <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int unsigned s = 1; s < STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign sync_o   = sync_q[STAGES-1];
   assign rise_c_o = sync_q[STAGES-1] & ~prev_q;
   assign fall_c_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/apb_gpio_ctrl.sv
// APB4 GPIO slave: wait-state FSM, register file, per-pin edge interrupts and
// aux/output pad mux.
module apb_gpio_ctrl
   import apb_gpio_pkg::*;
#(
   parameter int unsigned GPIO_W      = 32,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   input  logic [STRB_W-1:0] PSTRB,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              IRQ,
   input  logic [GPIO_W-1:0] aux_in,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic [GPIO_W-1:0] gpio_oe
);

   if (GPIO_W < 1 || GPIO_W > MAX_GPIO_W) begin : g_bad_gpio_w
      $error("apb_gpio_ctrl: GPIO_W must be 1..32");
   end
   if (WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait
      $error("apb_gpio_ctrl: WAIT_STATES must be 0..15");
   end
   if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
      $error("apb_gpio_ctrl: SYNC_STAGES must be 2..4");
   end
   if (ADDR_W < MIN_ADDR_W) begin : g_bad_addr_w
      $error("apb_gpio_ctrl: ADDR_W must be at least 6");
   end

   function automatic logic [GPIO_W-1:0] merge(input logic [GPIO_W-1:0] old_v,
                                                input logic [GPIO_W-1:0] m,
                                                input logic [GPIO_W-1:0] v);
      return (old_v & ~m) | (v & m);
   endfunction

   apb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] prdata_q, prdata_d;
   logic              irq_q, irq_d;
   logic              ie_q, ie_d;
   logic [GPIO_W-1:0] out_q, out_d, oe_q, oe_d, aux_q, aux_d;
   logic [GPIO_W-1:0] inte_q, inte_d, ptrig_q, ptrig_d, both_q, both_d;
   logic [GPIO_W-1:0] ints_q, ints_d;

   logic              setup_c, pready_c, wr_c, addr_err_c;
   logic [OFF_W-1:0]  off_c;
   logic [DATA_W-1:0] mask_full_c, rdata_c;
   logic [GPIO_W-1:0] wmask_c, wdata_c;
   logic [GPIO_W-1:0] in_sync_c, rise_c, fall_c, event_c;

   gpio_sync_edge #(
      .W      (GPIO_W),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i    (PCLK),
      .rst_ni   (PRESETn),
      .d_i      (gpio_in),
      .sync_o   (in_sync_c),
      .rise_c_o (rise_c),
      .fall_c_o (fall_c)
   );

   // Only PADDR[5:2] selects a register; everything else must be zero
   assign off_c       = PADDR[5:2];
   assign addr_err_c  = (PADDR[1:0] != 2'b00) || ((PADDR >> 6) != '0) || (off_c > REG_CTRL);
   assign mask_full_c = strb_mask(PSTRB);
   assign wmask_c     = mask_full_c[GPIO_W-1:0];
   assign wdata_c     = PWDATA[GPIO_W-1:0];

   // Bits above GPIO_W are intentionally dropped for narrow instances
   logic unused_c;
   assign unused_c = ^{PWDATA, mask_full_c};

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (PSEL && !PENABLE) state_d = WAIT;
         WAIT:    if (!PSEL || (PENABLE && cnt_q == '0)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      setup_c  = 1'b0;
      pready_c = 1'b0;
      case (state_q)
         IDLE:    setup_c  = PSEL && !PENABLE;
         WAIT:    pready_c = PSEL && PENABLE && (cnt_q == '0);
         default: ;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (setup_c) begin
         cnt_d = CNT_W'(WAIT_STATES);
      end else if (state_q == WAIT && PSEL && cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_comb begin
      rdata_c = '0;
      case (off_c)
         REG_IN:    rdata_c = DATA_W'(in_sync_c);
         REG_OUT:   rdata_c = DATA_W'(out_q);
         REG_OE:    rdata_c = DATA_W'(oe_q);
         REG_AUX:   rdata_c = DATA_W'(aux_q);
         REG_INTE:  rdata_c = DATA_W'(inte_q);
         REG_PTRIG: rdata_c = DATA_W'(ptrig_q);
         REG_BOTH:  rdata_c = DATA_W'(both_q);
         REG_INTS:  rdata_c = DATA_W'(ints_q);
         REG_CTRL:  rdata_c = DATA_W'(ie_q);
         default:   rdata_c = '0;
      endcase
      if (addr_err_c) rdata_c = '0;
   end

   assign prdata_d = setup_c ? rdata_c : prdata_q;
   assign wr_c     = pready_c && PWRITE && !addr_err_c;
   assign event_c  = inte_q & ((both_q & (rise_c | fall_c)) |
                               (~both_q & ((ptrig_q & rise_c) | (~ptrig_q & fall_c))));

   // Register file; a new edge event overrides a same-cycle W1C
   always_comb begin
      out_d   = out_q;
      oe_d    = oe_q;
      aux_d   = aux_q;
      inte_d  = inte_q;
      ptrig_d = ptrig_q;
      both_d  = both_q;
      ints_d  = ints_q;
      ie_d    = ie_q;
      if (wr_c) begin
         case (off_c)
            REG_OUT:   out_d   = merge(out_q, wmask_c, wdata_c);
            REG_OE:    oe_d    = merge(oe_q, wmask_c, wdata_c);
            REG_AUX:   aux_d   = merge(aux_q, wmask_c, wdata_c);
            REG_INTE:  inte_d  = merge(inte_q, wmask_c, wdata_c);
            REG_PTRIG: ptrig_d = merge(ptrig_q, wmask_c, wdata_c);
            REG_BOTH:  both_d  = merge(both_q, wmask_c, wdata_c);
            REG_INTS:  ints_d  = ints_q & ~(wdata_c & wmask_c);
            REG_CTRL:  if (PSTRB[0]) ie_d = PWDATA[CTRL_IE];
            default:   ;
         endcase
      end
      ints_d = ints_d | event_c;
   end

   assign irq_d = ie_q && (|(ints_q & inte_q));

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt_q    <= '0;
         prdata_q <= '0;
         irq_q    <= 1'b0;
         ie_q     <= 1'b0;
         out_q    <= '0;
         oe_q     <= '0;
         aux_q    <= '0;
         inte_q   <= '0;
         ptrig_q  <= '0;
         both_q   <= '0;
         ints_q   <= '0;
      end else begin
         cnt_q    <= cnt_d;
         prdata_q <= prdata_d;
         irq_q    <= irq_d;
         ie_q     <= ie_d;
         out_q    <= out_d;
         oe_q     <= oe_d;
         aux_q    <= aux_d;
         inte_q   <= inte_d;
         ptrig_q  <= ptrig_d;
         both_q   <= both_d;
         ints_q   <= ints_d;
      end
   end

   assign PRDATA   = prdata_q;
   assign PREADY   = pready_c;
   assign PSLVERR  = pready_c && addr_err_c;
   assign IRQ      = irq_q;
   assign gpio_out = (aux_q & aux_in) | (~aux_q & out_q);
   assign gpio_oe  = oe_q;

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// Self-checking bench: a 32-pin zero-wait instance and an 8-pin three-wait instance.
module tb_apb_gpio_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel, penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] aux_in, gpio_in;
   int          tgt;

   logic        psel0, psel1;
   logic [31:0] prdata0, prdata1, gout0, goe0;
   logic [7:0]  gout1, goe1;
   logic        pready0, pready1, pslverr0, pslverr1, irq0, irq1;
   logic [31:0] prdata_m;
   logic        pready_m, pslverr_m;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   assign psel0     = psel && (tgt == 0);
   assign psel1     = psel && (tgt == 1);
   assign prdata_m  = (tgt == 0) ? prdata0 : prdata1;
   assign pready_m  = (tgt == 0) ? pready0 : pready1;
   assign pslverr_m = (tgt == 0) ? pslverr0 : pslverr1;

   apb_gpio_ctrl #(.GPIO_W(32), .ADDR_W(8), .WAIT_STATES(0), .SYNC_STAGES(2)) dut0 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0), .PREADY(pready0),
      .PSLVERR(pslverr0), .IRQ(irq0), .aux_in(aux_in), .gpio_in(gpio_in),
      .gpio_out(gout0), .gpio_oe(goe0));

   apb_gpio_ctrl #(.GPIO_W(8), .ADDR_W(8), .WAIT_STATES(3), .SYNC_STAGES(3)) dut1 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata1), .PREADY(pready1),
      .PSLVERR(pslverr1), .IRQ(irq1), .aux_in(aux_in[7:0]), .gpio_in(gpio_in[7:0]),
      .gpio_out(gout1), .gpio_oe(goe1));

   // Reference model: register contents per instance, indexed by word offset
   logic [31:0] mreg [2][9];
   int          mw [2]   = '{32, 8};
   int          mwait [2] = '{0, 3};

   function automatic logic [31:0] wmask(input int d);
      return (mw[d] >= 32) ? 32'hFFFF_FFFF : ((32'h1 << mw[d]) - 32'h1);
   endfunction

   function automatic bit addr_bad(input logic [7:0] a);
      return (a > 8'h23) || (a[1:0] != 2'b00);
   endfunction

   task automatic m_reset();
      for (int d = 0; d < 2; d++)
         for (int r = 0; r < 9; r++) mreg[d][r] = '0;
   endtask

   task automatic m_write(input int d, input logic [7:0] a, input logic [31:0] wd, input logic [3:0] st);
      int idx;
      if (addr_bad(a)) return;
      idx = int'(a) / 4;
      if (idx == 0) return;
      for (int b = 0; b < 4; b++)
         if (st[b]) mreg[d][idx][b*8 +: 8] = wd[b*8 +: 8];
      mreg[d][idx] = mreg[d][idx] & wmask(d);
   endtask

   function automatic logic [31:0] m_read(input int d, input logic [7:0] a);
      if (addr_bad(a)) return '0;
      if (a == 8'h00) return gpio_in & wmask(d);
      return mreg[d][int'(a) / 4];
   endfunction

   function automatic logic [31:0] m_pins(input int d);
      return ((mreg[d][3] & aux_in) | (~mreg[d][3] & mreg[d][1])) & wmask(d);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   // One APB transfer; entered and left one time unit after a rising edge
   task automatic apb(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output bit er, output int ncyc);
      bit done;
      done = 1'b0;
      rd = '0; er = 1'b0; ncyc = 0;
      tgt = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
      @(posedge clk); #1;
      penable = 1'b1;
      while (!done && ncyc < 64) begin
         #1;
         ncyc++;
         if (pready_m) begin
            rd = prdata_m; er = pslverr_m; done = 1'b1;
         end
         @(posedge clk); #1;
      end
      psel = 1'b0; penable = 1'b0;
      if (!done) begin
         n_total++;
         $display("FAIL apb_timeout: no PREADY within %0d cycles, dut%0d addr 0x%02h", ncyc, d, a);
      end
   endtask

   logic [31:0] rd;
   bit          er;
   int          nc;

   task automatic wr_reg(input int d, input logic [7:0] a, input logic [31:0] wd);
      apb(d, 1'b1, a, wd, 4'hF, rd, er, nc);
      m_write(d, a, wd, 4'hF);
   endtask

   task automatic rd_chk(input string nm, input int d, input logic [7:0] a, input logic [31:0] exp);
      apb(d, 1'b0, a, '0, 4'h0, rd, er, nc);
      chk(nm, rd, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rd;
      bit          exp_err;
      logic [31:0] exp_out;
   } vec_t;

   vec_t vecs [15];
   logic [7:0] bad_list [6] = '{8'h24, 8'h3C, 8'h05, 8'h0E, 8'h44, 8'h84};

   initial begin
      vecs[0]  = '{1'b1, 8'h04, 32'hA5A5_00FF, 4'b0011, 32'h0,         1'b0, 32'h0000_00FF};
      vecs[1]  = '{1'b0, 8'h04, 32'h0,         4'b0000, 32'h0000_00FF, 1'b0, 32'h0000_00FF};
      vecs[2]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b0, 32'h0000_00FF};
      vecs[3]  = '{1'b0, 8'h08, 32'h0,         4'b0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_00FF};
      vecs[4]  = '{1'b1, 8'h0C, 32'h0000_000F, 4'b1111, 32'h0,         1'b0, 32'h0000_00F5};
      vecs[5]  = '{1'b0, 8'h0C, 32'h0,         4'b0000, 32'h0000_000F, 1'b0, 32'h0000_00F5};
      vecs[6]  = '{1'b0, 8'h00, 32'h0,         4'b0000, 32'h0,         1'b0, 32'h0000_00F5};
      vecs[7]  = '{1'b1, 8'h00, 32'h1234_5678, 4'b1111, 32'h0,         1'b0, 32'h0000_00F5};
      vecs[8]  = '{1'b0, 8'h24, 32'h0,         4'b0000, 32'h0,         1'b1, 32'h0000_00F5};
      vecs[9]  = '{1'b1, 8'h05, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b1, 32'h0000_00F5};
      vecs[10] = '{1'b0, 8'h84, 32'h0,         4'b0000, 32'h0,         1'b1, 32'h0000_00F5};
      vecs[11] = '{1'b1, 8'h84, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b1, 32'h0000_00F5};
      vecs[12] = '{1'b0, 8'h04, 32'h0,         4'b0000, 32'h0000_00FF, 1'b0, 32'h0000_00F5};
      vecs[13] = '{1'b1, 8'h20, 32'hFFFF_FFFF, 4'b1110, 32'h0,         1'b0, 32'h0000_00F5};
      vecs[14] = '{1'b0, 8'h20, 32'h0,         4'b0000, 32'h0,         1'b0, 32'h0000_00F5};

      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; tgt = 0;
      aux_in = '0; gpio_in = '0;
      m_reset();
      cycles(2);
      chk("rst_outputs0", {prdata0[15:0], 12'h0, pready0, pslverr0, irq0, 1'b0}, 32'h0);
      chk("rst_pins0", gout0 | goe0, 32'h0);
      chk("rst_outputs1", {prdata1[23:0], gout1}, 32'h0);
      chk("rst_misc1", {28'h0, pready1, pslverr1, irq1, |goe1}, 32'h0);
      rst_n = 1'b1;
      cycles(1);

      // Read IN straight after reset; latency in ACCESS cycles
      for (int d = 0; d < 2; d++) begin
         apb(d, 1'b0, 8'h00, '0, 4'h0, rd, er, nc);
         chk($sformatf("rst_in_rd%0d", d), rd, 32'h0);
         chk($sformatf("rst_in_err%0d", d), 32'(er), 32'h0);
         chk($sformatf("rst_in_lat%0d", d), 32'(nc), 32'(mwait[d] + 1));
      end

      // Table-driven register accesses on the 32-pin instance
      aux_in = 32'h0000_0005;
      for (int i = 0; i < 15; i++) begin
         apb(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, nc);
         if (vecs[i].wr) m_write(0, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
         else chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d_pins", i), gout0, vecs[i].exp_out);
      end
      chk("oe_pins", goe0, 32'hFFFF_FFFF);

      // Rising-edge interrupt on pin 0
      wr_reg(0, 8'h10, 32'h1);
      wr_reg(0, 8'h14, 32'h1);
      wr_reg(0, 8'h20, 32'h1);
      chk("irq_idle", 32'(irq0), 32'h0);
      gpio_in[0] = 1'b1;
      cycles(3);
      chk("irq_before", 32'(irq0), 32'h0);
      cycles(1);
      chk("irq_set", 32'(irq0), 32'h1);
      rd_chk("ints_rise", 0, 8'h1C, 32'h1);
      wr_reg(0, 8'h1C, 32'h1);
      chk("irq_hold", 32'(irq0), 32'h1);
      cycles(1);
      chk("irq_clr", 32'(irq0), 32'h0);
      rd_chk("ints_clr", 0, 8'h1C, 32'h0);

      // Both-edge interrupt on pin 3 (PTRIG=1 so the fall needs BOTH)
      wr_reg(0, 8'h14, 32'h9);
      wr_reg(0, 8'h18, 32'h8);
      wr_reg(0, 8'h10, 32'h9);
      gpio_in[3] = 1'b1;
      cycles(4);
      rd_chk("both_rise", 0, 8'h1C, 32'h8);
      chk("both_irq", 32'(irq0), 32'h1);
      wr_reg(0, 8'h1C, 32'h8);
      cycles(2);
      rd_chk("both_clr1", 0, 8'h1C, 32'h0);
      gpio_in[3] = 1'b0;
      cycles(4);
      rd_chk("both_fall", 0, 8'h1C, 32'h8);
      wr_reg(0, 8'h1C, 32'h8);
      cycles(2);
      rd_chk("both_clr2", 0, 8'h1C, 32'h0);
      // W1C commit lands on the same edge the new event sets INTS
      gpio_in[3] = 1'b1;
      cycles(1);
      wr_reg(0, 8'h1C, 32'h8);
      rd_chk("set_wins", 0, 8'h1C, 32'h8);
      wr_reg(0, 8'h10, 32'h0);
      rd_chk("inte_off_keep", 0, 8'h1C, 32'h8);
      cycles(1);
      chk("inte_off_irq", 32'(irq0), 32'h0);
      rd_chk("in_pins", 0, 8'h00, 32'h9);

      // Narrow instance: upper bits, errors, aborted transfer
      wr_reg(1, 8'h04, 32'hFFFF_FFFF);
      rd_chk("w8_out", 1, 8'h04, 32'h0000_00FF);
      chk("w8_lat", 32'(nc), 32'h4);
      for (int i = 0; i < 3; i++) begin
         apb(1, 1'b0, bad_list[i*2+1], '0, 4'h0, rd, er, nc);
         chk($sformatf("w8_bad%0d", i), {rd[30:0], er}, 32'h1);
      end
      apb(1, 1'b1, 8'h84, 32'h0, 4'hF, rd, er, nc);
      chk("w8_bad_wr_err", 32'(er), 32'h1);
      rd_chk("w8_bad_wr_keep", 1, 8'h04, 32'h0000_00FF);

      tgt = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04;
      pwdata = 32'h0000_003C; pstrb = 4'hF;
      cycles(1);
      penable = 1'b1;
      cycles(1);
      #1 chk("drop_nready", 32'(pready1), 32'h0);
      psel = 1'b0; penable = 1'b0;
      cycles(2);
      rd_chk("drop_nocommit", 1, 8'h04, 32'h0000_00FF);

      // Randomised OUT/OE/AUX traffic plus bad addresses against the model
      gpio_in = $urandom;
      cycles(6);
      for (int i = 0; i < 60; i++) begin
         int d, op;
         logic [7:0]  a;
         logic [31:0] wd;
         logic [3:0]  st;
         bit          w;
         d  = i % 2;
         op = int'($urandom_range(0, 4));
         wd = $urandom;
         st = 4'($urandom);
         aux_in = $urandom;
         if (op <= 2) begin
            a = 8'($urandom_range(1, 3) * 4);
            w = 1'b1;
         end else if (op == 3) begin
            a = 8'($urandom_range(0, 3) * 4);
            w = 1'b0;
         end else begin
            a = bad_list[$urandom_range(0, 5)];
            w = 1'($urandom);
         end
         apb(d, w, a, wd, st, rd, er, nc);
         if (w) m_write(d, a, wd, st);
         else chk($sformatf("rnd%0d_rd", i), rd, m_read(d, a));
         chk($sformatf("rnd%0d_err", i), 32'(er), 32'(addr_bad(a)));
         chk($sformatf("rnd%0d_out", i), (d == 0) ? gout0 : 32'(gout1), m_pins(d));
         chk($sformatf("rnd%0d_oe", i), (d == 0) ? goe0 : 32'(goe1), mreg[d][2]);
      end

      // Reset in the middle of a wait-stated write
      wr_reg(1, 8'h04, 32'h0);
      tgt = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04;
      pwdata = 32'h0000_0055; pstrb = 4'hF;
      cycles(1);
      penable = 1'b1;
      cycles(1);
      rst_n = 1'b0;
      #1 chk("mid_rst_nready", 32'(pready1), 32'h0);
      psel = 1'b0; penable = 1'b0;
      m_reset();
      cycles(2);
      rst_n = 1'b1;
      cycles(1);
      chk("mid_rst_pins", {gout1, goe1}, 32'h0);
      rd_chk("mid_rst_out", 1, 8'h04, 32'h0);
      chk("mid_rst_irq0", 32'(irq0), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
